// File: rtl/mem_arb_pkg.sv
// Shared types for the cacheline-port arbiter: FSM states, requester IDs and the grant rule.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_D    = 2'd0,
        REQ_I    = 2'd1,
        REQ_P    = 2'd2,
        REQ_NONE = 2'd3
    } arb_req_id_t;

    localparam int LINE_OFFSET_BITS = 5;

    // Promoted (starving) requesters sit above D; when both are promoted I beats P.
    function automatic arb_req_id_t pick_winner(
        input logic d_req,
        input logic i_req,
        input logic p_req,
        input logic i_prom,
        input logic p_prom
    );
        arb_req_id_t w;
        if (i_prom && i_req)      w = REQ_I;
        else if (p_prom && p_req) w = REQ_P;
        else if (d_req)           w = REQ_D;
        else if (i_req)           w = REQ_I;
        else if (p_req)           w = REQ_P;
        else                      w = REQ_NONE;
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_age_ctr.sv
// 8-bit saturating age counter for one requester; promote_o rises once it has lost STARVE_LIMIT times.
module mem_arb_age_ctr #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic promote_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'd0;
        else if (inc_i && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign promote_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the cacheline-adaptor port between D-cache, I-cache and prefetcher, fixed priority D > I > P.
// Define MEM_ARB_AGE_GUARD_EN to add age counters that promote a starving I or P above D.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              p_read,
    input  logic [ADDR_W-1:0] p_addr,
    output logic [LINE_W-1:0] p_rdata,
    output logic              p_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    arb_state_t        state_q, state_d;
    arb_req_id_t       owner_q, owner_d, winner;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_prom, p_prom, busy;

    if (STARVE_LIMIT < 2 || STARVE_LIMIT > 255) begin : g_limit_check
        $error("mem_req_arbiter: STARVE_LIMIT must be within 2..255");
    end

`ifdef MEM_ARB_AGE_GUARD_EN
    // Counters only advance on lost IDLE-cycle arbitrations; any deassertion clears them.
    mem_arb_age_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_i (
        .clk_i     (clk),
        .rst_n_i   (reset_n),
        .inc_i     (!busy && i_read && (winner != REQ_I)),
        .clr_i     (!i_read || (!busy && (winner == REQ_I))),
        .promote_o (i_prom)
    );

    mem_arb_age_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_p (
        .clk_i     (clk),
        .rst_n_i   (reset_n),
        .inc_i     (!busy && p_read && (winner != REQ_P)),
        .clr_i     (!p_read || (!busy && (winner == REQ_P))),
        .promote_o (p_prom)
    );
`else
    assign i_prom = 1'b0;
    assign p_prom = 1'b0;
`endif

    assign busy   = (state_q == BUSY);
    assign winner = pick_winner(d_read | d_write, i_read, p_read, i_prom, p_prom);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= REQ_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Every IDLE cycle re-latches the winner, so an idle arbiter holds cleared latches.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                owner_d = winner;
                we_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                case (winner)
                    REQ_D: begin
                        we_d    = d_write;
                        addr_d  = d_addr & ~OFFSET_MASK;
                        wdata_d = d_wdata;
                    end
                    REQ_I:   addr_d = i_addr & ~OFFSET_MASK;
                    REQ_P:   addr_d = p_addr & ~OFFSET_MASK;
                    default: ;
                endcase
                if (winner != REQ_NONE)
                    state_d = BUSY;
            end
            BUSY: begin
                if (mem_resp)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = busy & ~we_q;
        mem_write   = busy & we_q;
        mem_address = busy ? addr_q : '0;
        mem_wdata   = busy ? wdata_q : '0;
        d_resp      = busy & mem_resp & (owner_q == REQ_D);
        i_resp      = busy & mem_resp & (owner_q == REQ_I);
        p_resp      = busy & mem_resp & (owner_q == REQ_P);
        d_rdata     = mem_rdata;
        i_rdata     = mem_rdata;
        p_rdata     = mem_rdata;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Three-requester arbiter that shares the single cacheline-adaptor port between the data cache, the instruction cache and a next-line prefetch buffer. It sits between the caches and `cacheline_adaptor`, latches one request at a time, drives it to the adaptor and routes the response back. Fixed priority is D > I > P. An optional age guard prevents starvation of the lower-priority requesters.

## Interface
Parameters:
- `STARVE_LIMIT`, 16: number of lost arbitration cycles before a requester is promoted. Range 2..255. Used only with the age guard.
- `ADDR_W`, 32: address width.
- `LINE_W`, 256: cacheline width.

Ports:
- `clk`, in, 1: the single clock. Everything is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `d_read`, `d_write`, in, 1 each: D-cache request. Held until `d_resp`.
- `d_addr`, in, ADDR_W: D-cache line address.
- `d_wdata`, in, LINE_W: D-cache write-back line.
- `d_rdata`, out, LINE_W: D-cache read line.
- `d_resp`, out, 1: D-cache completion.
- `i_read`, in, 1: I-cache request.
- `i_addr`, in, ADDR_W: I-cache line address.
- `i_rdata`, out, LINE_W: I-cache read line.
- `i_resp`, out, 1: I-cache completion.
- `p_read`, in, 1: prefetch request.
- `p_addr`, in, ADDR_W: prefetch line address.
- `p_rdata`, out, LINE_W: prefetch read line.
- `p_resp`, out, 1: prefetch completion.
- `mem_read`, `mem_write`, out, 1 each: request to the adaptor.
- `mem_address`, out, ADDR_W: address to the adaptor.
- `mem_wdata`, out, LINE_W: write line to the adaptor.
- `mem_rdata`, in, LINE_W: read line from the adaptor.
- `mem_resp`, in, 1: adaptor completion.

## Operation
State machine states: IDLE, BUSY.

**IDLE**
- Sample the requests and pick a winner by priority D > I > P.
- If D asserts both `d_read` and `d_write`, the write wins. This is a protocol error, but the behaviour is defined.
- Latch the winner's ID, the operation, the address with bits [4:0] forced to 0, and the wdata. Go to BUSY.
- No request: stay in IDLE with all mem outputs at 0.

**BUSY**
- `mem_read`/`mem_write`/`mem_address`/`mem_wdata` are driven from the latched registers. They hold steady even if the requester changes its inputs.
- On `mem_resp`, the owner's `*_resp` is driven combinationally high in the same cycle, and its `*_rdata` = `mem_rdata`. Next state is IDLE.
- The non-owners' `*_resp` stay 0 at all times. The `*_rdata` outputs are driven by `mem_rdata` for all requesters. Only `*_resp` qualifies them.

**Boundary rules**
- A requester that drops its request mid-transaction still gets its `*_resp` pulse.
- A request still high in the IDLE cycle after its own resp is treated as a new request. Caches deassert on the resp edge.
- Async reset mid-BUSY:
  - Go to IDLE immediately and clear all outputs and latches.
  - The in-flight transaction is abandoned. The adaptor shares `reset_n`.
- Reset values: all outputs are 0, state is IDLE, and the age counters are 0.

## Timing
- A request is sampled in IDLE at cycle t. `mem_read`/`mem_write` are high from t+1.
- `mem_resp` at cycle u gives `*_resp` in cycle u, and the mem request drops at u+1.
- The next grant is evaluated at u+1, and its mem request is issued at u+2. There is one mandatory IDLE cycle between transactions.
- Arbiter overhead is 2 cycles per transaction, plus the adaptor latency.
- `*_resp` is high for exactly one cycle per transaction.

## Configuration
Macro `MEM_ARB_AGE_GUARD_EN`.

**Defined:**
- There is one 8-bit saturating age counter each for I and P.
- A counter increments in each IDLE cycle where that requester is asserted but loses arbitration.
- It clears when the requester is granted or deasserts.
- A counter at `>= STARVE_LIMIT` promotes its requester above D. If both are promoted, I wins over P.

**Undefined:**
- Strict D > I > P priority. No counters exist.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_t` (IDLE, BUSY)
  - `arb_req_id_t` (REQ_D, REQ_I, REQ_P, REQ_NONE)
  - `LINE_OFFSET_BITS` = 5
- Sub-module `mem_arb_age_ctr`: one saturating age counter with inc, clr and promote ports. It is instantiated twice under the macro.

## Test plan
- **Single D read:** `d_read` at 0x0000_1234 in cycle 0 → `mem_read`=1 and `mem_address`=0x0000_1220 at cycle 1. `mem_resp` at cycle 5 → `d_resp`=1 at cycle 5 with `d_rdata`=`mem_rdata`, and `mem_read`=0 at cycle 6.
- **Simultaneous D write and I read:** → write issued first with `mem_wdata`=`d_wdata`. After `d_resp`, `i_read` is granted and `mem_read` rises 2 cycles after `d_resp`.
- **All three continuously requesting, macro off:** → P is never granted over 100 transactions.
- **Macro on, `STARVE_LIMIT`=4, D and P continuously requesting:** → P is granted after 4 lost arbitration cycles, and its counter then reads 0.
- **Mid-transaction change:** change `i_addr` during BUSY → `mem_address` is unchanged. Drop `i_read` during BUSY → `i_resp` still pulses once.
- **Reset mid-transaction:** assert `reset_n`=0 in BUSY → all outputs are 0 in the same cycle. After release with no requests, `mem_read` stays 0.
